knn_image_loader: RTL and testbench

//  Producer side of the kNN classifier's test-image/valid interface.
//  - Accepts a 16x16 grayscale pixel stream over a valid/ready handshake.
//  - Binarises each pixel against a threshold and packs the frame into the 256-bit test image.
//  - Drives the classifier's valid line for a fixed scan window, then captures its min-distance,
//    min-row and result outputs.
//  - Presents the captured result as one classification record on a valid/ready output port.

---
 rtl/knn_image_loader.sv | 170 +++++++++++++++++
 tb/tb_knn_image_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/knn_image_loader.sv
// knn_image_loader
//   Producer side of the kNN classifier interface. Collects a 16x16 grayscale
//   frame over a valid/ready pixel stream, binarises each pixel against THRESH
//   and packs the frame into the test image. It then holds the classifier's
//   valid line high for KNN_WAIT cycles, captures the classifier outputs, and
//   offers them as one record on a valid/ready output port. After the record
//   is taken, the loader idles for GAP cycles and then accepts the next frame.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. The producer holds valid and its payload stable until the
//   transfer happens. Ready may depend on state but never on valid.
//
// Ports
//   clk, rst            clock (posedge); asynchronous active-low reset
//   pix_data/valid/last pixel stream in; pix_last is only checked
//   pix_ready           high while collecting a frame
//   knn_test_image      packed binary image, bit k = pixel k
//   knn_valid           classifier start/hold, high for KNN_WAIT cycles
//   knn_current_min/knn_min_row/knn_result  classifier outputs, captured
//   cls_valid/ready     classification record handshake
//   cls_result/cls_min_dist/cls_min_row     captured record payload
//   frame_err           sticky: pix_last seen at the wrong pixel position
//   state_dbg           current FSM state encoding
module knn_image_loader #(
    parameter int PIX_W    = 8,
    parameter int NUM_PIX  = 256,
    parameter int THRESH   = 128,
    parameter int KNN_WAIT = 604,
    parameter int GAP      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               pix_last,
    output logic [NUM_PIX-1:0] knn_test_image,
    output logic               knn_valid,
    input  logic [8:0]         knn_current_min,
    input  logic [8:0]         knn_min_row,
    input  logic               knn_result,
    output logic               cls_valid,
    input  logic               cls_ready,
    output logic               cls_result,
    output logic [8:0]         cls_min_dist,
    output logic [8:0]         cls_min_row,
    output logic               frame_err,
    output logic [1:0]         state_dbg
);

    localparam int CNT_W  = $clog2(NUM_PIX);
    localparam int WAIT_W = $clog2(KNN_WAIT);
    localparam int GAP_W  = $clog2(GAP) + 1;

    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(NUM_PIX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(KNN_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [PIX_W-1:0]  THRESH_V  = PIX_W'(THRESH);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_KNN = 2'd1,
        REPORT   = 2'd2,
        GAP_ST   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  pix_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic pix_accept;
    logic at_last_pix;

    assign state_dbg   = state;
    assign pix_accept  = pix_valid & pix_ready;
    assign at_last_pix = (pix_cnt == LAST_PIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // knn_valid and cls_valid are pure state decodes, so they can never be
    // high together and knn_valid can only rise on the COLLECT -> WAIT_KNN step.
    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        knn_valid  = 1'b0;
        cls_valid  = 1'b0;
        case (state)
            COLLECT: begin
                pix_ready = 1'b1;
                if (pix_valid && at_last_pix) begin
                    state_next = WAIT_KNN;
                end
            end
            WAIT_KNN: begin
                knn_valid = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                cls_valid = 1'b1;
                if (cls_ready) begin
                    state_next = GAP_ST;
                end
            end
            GAP_ST: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt        <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            knn_test_image <= '0;
            cls_result     <= 1'b0;
            cls_min_dist   <= '0;
            cls_min_row    <= '0;
            frame_err      <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    wait_cnt <= '0;
                    if (pix_accept) begin
                        // Overwrite in place; a full frame rewrites every bit.
                        knn_test_image[pix_cnt] <= (pix_data >= THRESH_V);
                        // Frame length is fixed; pix_last only raises the flag.
                        if (pix_last != at_last_pix) begin
                            frame_err <= 1'b1;
                        end
                        pix_cnt <= at_last_pix ? '0 : pix_cnt + 1'b1;
                    end
                end
                WAIT_KNN: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        cls_result   <= knn_result;
                        cls_min_dist <= knn_current_min;
                        cls_min_row  <= knn_min_row;
                    end
                end
                REPORT: begin
                    gap_cnt <= '0;
                end
                GAP_ST: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_image_loader.sv
module tb_knn_image_loader;

    logic         clk;
    logic         rst;
    logic [7:0]   pix_data;
    logic         pix_valid;
    logic         pix_ready;
    logic         pix_last;
    logic [255:0] knn_test_image;
    logic         knn_valid;
    logic [8:0]   knn_current_min;
    logic [8:0]   knn_min_row;
    logic         knn_result;
    logic         cls_valid;
    logic         cls_ready;
    logic         cls_result;
    logic [8:0]   cls_min_dist;
    logic [8:0]   cls_min_row;
    logic         frame_err;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    knn_image_loader dut (
        .clk             (clk),
        .rst             (rst),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_last        (pix_last),
        .knn_test_image  (knn_test_image),
        .knn_valid       (knn_valid),
        .knn_current_min (knn_current_min),
        .knn_min_row     (knn_min_row),
        .knn_result      (knn_result),
        .cls_valid       (cls_valid),
        .cls_ready       (cls_ready),
        .cls_result      (cls_result),
        .cls_min_dist    (cls_min_dist),
        .cls_min_row     (cls_min_row),
        .frame_err       (frame_err),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // frame scenarios: pixel mode 0=all 0xFF, 1=127/128 alternating,
    // 2=all 0x00, 3=ramp (pixel k = k)
    typedef struct {
        int           mode;
        int           idle;
        int           last_pos;
        logic [8:0]   kmin;
        logic [8:0]   krow;
        logic         kres;
        int           rdy_delay;
        logic [255:0] exp_img;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int k);
        case (mode)
            0:       return 8'hFF;
            1:       return (k % 2 == 0) ? 8'd127 : 8'd128;
            2:       return 8'h00;
            default: return 8'(k);
        endcase
    endfunction

    // driver: wait idle cycles, then present one pixel until accepted
    task automatic feed_pixel(input logic [7:0] d, input logic last, input int idle);
        int n;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        n = 0;
        while (!pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("pix_accept_timeout", 256'(n), 256'(0));
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int   cnt;
        int   viol;
        int   g;
        v = vecs[idx];
        knn_current_min = v.kmin;
        knn_min_row     = v.krow;
        knn_result      = v.kres;
        for (int k = 0; k < 256; k++) begin
            feed_pixel(pix_val(v.mode, k), (k == v.last_pos), v.idle);
        end
        @(negedge clk);
        check($sformatf("f%0d_knn_valid_rise", idx), 256'(knn_valid), 256'(1));
        check($sformatf("f%0d_image", idx), knn_test_image, v.exp_img);
        cnt  = 0;
        viol = 0;
        while (knn_valid && cnt < 2000) begin
            if (pix_ready || cls_valid) viol++;
            if (knn_test_image !== v.exp_img) viol++;
            cnt++;
            @(negedge clk);
        end
        check($sformatf("f%0d_knn_valid_len", idx), 256'(cnt), 256'(604));
        check($sformatf("f%0d_wait_invariants", idx), 256'(viol), 256'(0));
        check($sformatf("f%0d_cls_valid", idx), 256'(cls_valid), 256'(1));
        check($sformatf("f%0d_cls_fields", idx),
              256'({cls_result, cls_min_dist, cls_min_row}),
              256'({v.kres, v.kmin, v.krow}));
        check($sformatf("f%0d_frame_err", idx), 256'(frame_err), 256'(v.exp_err));
        viol = 0;
        for (int i = 0; i < v.rdy_delay; i++) begin
            @(negedge clk);
            if (!cls_valid || knn_valid || pix_ready) viol++;
            if ({cls_result, cls_min_dist, cls_min_row} !== {v.kres, v.kmin, v.krow}) viol++;
        end
        if (v.rdy_delay > 0) begin
            check($sformatf("f%0d_report_hold", idx), 256'(viol), 256'(0));
        end
        cls_ready = 1'b1;
        @(posedge clk);
        #1;
        cls_ready = 1'b0;
        @(negedge clk);
        check($sformatf("f%0d_cls_drop", idx), 256'(cls_valid), 256'(0));
        check($sformatf("f%0d_cls_retain", idx), 256'(cls_min_dist), 256'(v.kmin));
        g    = 0;
        viol = 0;
        while (!pix_ready && g < 10) begin
            if (knn_valid || cls_valid) viol++;
            g++;
            @(negedge clk);
        end
        check($sformatf("f%0d_gap_len", idx), 256'(g), 256'(2));
        check($sformatf("f%0d_gap_invariants", idx), 256'(viol), 256'(0));
    endtask

    initial begin
        int cnt;
        vecs[0] = '{0, 0, 255, 9'd17,  9'd42,  1'b0, 0,  {256{1'b1}},                1'b0};
        vecs[1] = '{1, 0, 255, 9'd5,   9'd3,   1'b0, 0,  {128{2'b10}},               1'b0};
        vecs[2] = '{2, 0, 255, 9'd100, 9'd200, 1'b1, 50, {256{1'b0}},                1'b0};
        vecs[3] = '{1, 2, 255, 9'd9,   9'd150, 1'b1, 3,  {128{2'b10}},               1'b0};
        vecs[4] = '{3, 0, 100, 9'd33,  9'd7,   1'b0, 0,  {{128{1'b1}}, {128{1'b0}}}, 1'b1};
        vecs[5] = '{0, 1, 255, 9'h1FF, 9'h1AB, 1'b1, 2,  {256{1'b1}},                1'b1};

        rst             = 1'b0;
        pix_data        = '0;
        pix_valid       = 1'b0;
        pix_last        = 1'b0;
        cls_ready       = 1'b0;
        knn_current_min = '0;
        knn_min_row     = '0;
        knn_result      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst_image", knn_test_image, 256'(0));
        check("rst_valids", 256'({knn_valid, cls_valid, frame_err}), 256'(0));
        check("rst_cls", 256'({cls_result, cls_min_dist, cls_min_row}), 256'(0));
        check("rst_pix_ready", 256'(pix_ready), 256'(1));
        check("rst_state", 256'(state_dbg), 256'(0));

        for (int i = 0; i < 6; i++) begin
            run_frame(i);
        end

        // reset in the middle of the classifier wait window
        knn_current_min = 9'd1;
        knn_min_row     = 9'd2;
        knn_result      = 1'b0;
        for (int k = 0; k < 256; k++) begin
            feed_pixel(8'h00, (k == 255), 0);
        end
        cnt = 0;
        while (cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_wait_knn_valid", 256'(knn_valid), 256'(1));
        rst = 1'b0;
        #1;
        check("in_rst_valids", 256'({knn_valid, cls_valid}), 256'(0));
        check("in_rst_frame_err", 256'(frame_err), 256'(0));
        repeat (3) @(negedge clk);
        check("in_rst_hold", 256'({knn_valid, cls_valid}), 256'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_pix_ready", 256'(pix_ready), 256'(1));
        check("post_rst_image", knn_test_image, 256'(0));
        feed_pixel(8'hFF, 1'b0, 0);
        check("post_rst_pixel0", knn_test_image, 256'(1));
        for (int k = 1; k < 256; k++) begin
            feed_pixel(8'h00, (k == 255), 0);
        end
        @(negedge clk);
        check("post_rst_knn_valid", 256'(knn_valid), 256'(1));
        check("post_rst_frame_err", 256'(frame_err), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
